// File: rtl/ext_bus_if.sv
// Core request/response channel plus the multiplexed 16-bit external bus pins
// of the west pad ring, grouped for the bus-master sequencer.
interface ext_bus_if;
  logic        core_req_valid;
  logic        core_req_ready;
  logic        core_req_we;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_wdata;
  logic [3:0]  core_req_be;
  logic        core_rsp_valid;
  logic        core_rsp_ready;
  logic [31:0] core_rsp_rdata;
  logic        core_rsp_err;
  logic [15:0] bus_data_drv_b;
  logic        dbus_o_en_b;
  logic        dbus_i_en_b;
  logic [15:0] bus_data_recv_b;
  logic        bus_ale;
  logic        bus_cs_n;
  logic        bus_we_n;
  logic [1:0]  bus_be_n;
  logic        bus_rdy;

  // Sequencer side.
  modport master (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_be,
    input  core_rsp_ready, bus_data_recv_b, bus_rdy,
    output core_req_ready, core_rsp_valid, core_rsp_rdata, core_rsp_err,
    output bus_data_drv_b, dbus_o_en_b, dbus_i_en_b, bus_ale, bus_cs_n, bus_we_n, bus_be_n
  );

  // Core / pad-ring side.
  modport slave (
    output core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_be,
    output core_rsp_ready, bus_data_recv_b, bus_rdy,
    input  core_req_ready, core_rsp_valid, core_rsp_rdata, core_rsp_err,
    input  bus_data_drv_b, dbus_o_en_b, dbus_i_en_b, bus_ale, bus_cs_n, bus_we_n, bus_be_n
  );
endinterface

// File: rtl/ext_bus_ctrl.sv
// Converts one 32-bit core request into a multiplexed 16-bit external bus
// transaction (address hi/lo, up to two data halfwords, turnarounds, timeout).
module ext_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  ext_bus_if.master bus_io
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, TURN_R, DATA_LO, DATA_HI, TURN_B, RESP
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] drv_q, drv_d;
  logic        oe_q, oe_d, ie_q, ie_d;
  logic        ale_q, ale_d, cs_n_q, cs_n_d, we_n_q, we_n_d;
  logic [1:0]  be_n_q, be_n_d;

  logic   accept;
  state_e first_data, finish_state;

  assign accept       = bus_io.core_req_valid & req_ready_q;
  assign first_data   = (be_q[1:0] != 2'b00) ? DATA_LO : DATA_HI;
  assign finish_state = we_q ? RESP : TURN_B;

  function automatic logic [15:0] byte_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned (no latch); combinational blocks use blocking '=' only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE:    if (accept) state_d = ADDR_HI;
      ADDR_HI: state_d = ADDR_LO;
      ADDR_LO: begin
        cnt_d = '0;
        if (be_q == 4'b0000) state_d = RESP;
        else if (we_q)       state_d = first_data;
        else                 state_d = TURN_R;
      end
      TURN_R: begin
        cnt_d   = '0;
        state_d = first_data;
      end
      DATA_LO: begin
        if (bus_io.bus_rdy) begin
          if (!we_q) rdata_d[15:0] = bus_io.bus_data_recv_b & byte_mask(be_q[1:0]);
          if (be_q[3:2] != 2'b00) begin
            state_d = DATA_HI;
            cnt_d   = '0;
          end else begin
            state_d = finish_state;
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          err_d   = 1'b1;
          state_d = finish_state;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA_HI: begin
        if (bus_io.bus_rdy) begin
          if (!we_q) rdata_d[31:16] = bus_io.bus_data_recv_b & byte_mask(be_q[3:2]);
          state_d = finish_state;
        end else if (cnt_q == TIMEOUT_CNT) begin
          err_d   = 1'b1;
          state_d = finish_state;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN_B:  state_d = RESP;
      RESP:    if (bus_io.core_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response payload is only meaningful until the handshake completes.
    if (state_d == IDLE) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they belong to.
  always_comb begin
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    drv_d       = '0;
    oe_d        = 1'b0;
    ie_d        = 1'b0;
    ale_d       = 1'b0;
    cs_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = 2'b11;
    case (state_d)
      IDLE: req_ready_d = 1'b1;
      ADDR_HI: begin
        cs_n_d = 1'b0;
        ale_d  = 1'b1;
        oe_d   = 1'b1;
        drv_d  = bus_io.core_req_addr[31:16];
      end
      ADDR_LO: begin
        cs_n_d = 1'b0;
        ale_d  = 1'b1;
        oe_d   = 1'b1;
        drv_d  = addr_q[15:0];
      end
      TURN_R: cs_n_d = 1'b0;
      DATA_LO, DATA_HI: begin
        cs_n_d = 1'b0;
        be_n_d = (state_d == DATA_LO) ? ~be_q[1:0] : ~be_q[3:2];
        if (we_q) begin
          oe_d   = 1'b1;
          we_n_d = 1'b0;
          drv_d  = (state_d == DATA_LO) ? wdata_q[15:0] : wdata_q[31:16];
        end else begin
          ie_d = 1'b1;
        end
      end
      RESP:    rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      drv_q       <= '0;
      oe_q        <= 1'b0;
      ie_q        <= 1'b0;
      ale_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      drv_q       <= drv_d;
      oe_q        <= oe_d;
      ie_q        <= ie_d;
      ale_q       <= ale_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
    end
  end

  // NOTE: the latched request is plain datapath, always written on accept
  // before it is used, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus_io.core_req_we;
      addr_q  <= bus_io.core_req_addr;
      wdata_q <= bus_io.core_req_wdata;
      be_q    <= bus_io.core_req_be;
    end
  end

  assign bus_io.core_req_ready = req_ready_q;
  assign bus_io.core_rsp_valid = rsp_valid_q;
  assign bus_io.core_rsp_rdata = rdata_q;
  assign bus_io.core_rsp_err   = err_q;
  assign bus_io.bus_data_drv_b = drv_q;
  assign bus_io.dbus_o_en_b    = oe_q;
  assign bus_io.dbus_i_en_b    = ie_q;
  assign bus_io.bus_ale        = ale_q;
  assign bus_io.bus_cs_n       = cs_n_q;
  assign bus_io.bus_we_n       = we_n_q;
  assign bus_io.bus_be_n       = be_n_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl: write, read, wait states, timeout,
// mid-transaction reset and zero byte-enable request.
module tb_ext_bus_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ext_bus_if bus_if ();

  ext_bus_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"},     32'(bus_if.core_req_ready), 32'd1);
    check({tag, ".rsp_valid"}, 32'(bus_if.core_rsp_valid), 32'd0);
    check({tag, ".rdata"},     bus_if.core_rsp_rdata,      32'd0);
    check({tag, ".err"},       32'(bus_if.core_rsp_err),   32'd0);
    check({tag, ".drv"},       32'(bus_if.bus_data_drv_b), 32'd0);
    check({tag, ".oe"},        32'(bus_if.dbus_o_en_b),    32'd0);
    check({tag, ".ie"},        32'(bus_if.dbus_i_en_b),    32'd0);
    check({tag, ".ale"},       32'(bus_if.bus_ale),        32'd0);
    check({tag, ".cs_n"},      32'(bus_if.bus_cs_n),       32'd1);
    check({tag, ".we_n"},      32'(bus_if.bus_we_n),       32'd1);
    check({tag, ".be_n"},      32'(bus_if.bus_be_n),       32'd3);
  endtask

  task automatic send_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    bus_if.core_req_valid = 1'b1;
    bus_if.core_req_we    = we;
    bus_if.core_req_addr  = addr;
    bus_if.core_req_wdata = wdata;
    bus_if.core_req_be    = be;
    step();
    bus_if.core_req_valid = 1'b0;
  endtask

  task automatic rsp_handshake(input string tag);
    bus_if.core_rsp_ready = 1'b1;
    step();
    bus_if.core_rsp_ready = 1'b0;
    check_idle(tag);
  endtask

  // Pad enables must never both be active while out of reset.
  always @(negedge clk) begin
    if (rst_n) check("oe_ie_excl", 32'(bus_if.dbus_o_en_b & bus_if.dbus_i_en_b), 32'd0);
  end

  initial begin
    bus_if.core_req_valid  = 1'b0;
    bus_if.core_req_we     = 1'b0;
    bus_if.core_req_addr   = '0;
    bus_if.core_req_wdata  = '0;
    bus_if.core_req_be     = '0;
    bus_if.core_rsp_ready  = 1'b0;
    bus_if.bus_data_recv_b = '0;
    bus_if.bus_rdy         = 1'b1;

    step();
    step();
    rst_n = 1'b1;
    check_idle("reset");

    // Full write, zero wait states: rsp_valid five cycles after handshake.
    send_req(1'b1, 32'h8000_1234, 32'hDEAD_BEEF, 4'hF);
    check("wr.ah.drv",   32'(bus_if.bus_data_drv_b), 32'h8000);
    check("wr.ah.ale",   32'(bus_if.bus_ale),        32'd1);
    check("wr.ah.oe",    32'(bus_if.dbus_o_en_b),    32'd1);
    check("wr.ah.cs_n",  32'(bus_if.bus_cs_n),       32'd0);
    check("wr.ah.ready", 32'(bus_if.core_req_ready), 32'd0);
    step();
    check("wr.al.drv",   32'(bus_if.bus_data_drv_b), 32'h1234);
    check("wr.al.ale",   32'(bus_if.bus_ale),        32'd1);
    check("wr.al.oe",    32'(bus_if.dbus_o_en_b),    32'd1);
    step();
    check("wr.dl.drv",   32'(bus_if.bus_data_drv_b), 32'hBEEF);
    check("wr.dl.ale",   32'(bus_if.bus_ale),        32'd0);
    check("wr.dl.oe",    32'(bus_if.dbus_o_en_b),    32'd1);
    check("wr.dl.we_n",  32'(bus_if.bus_we_n),       32'd0);
    check("wr.dl.be_n",  32'(bus_if.bus_be_n),       32'd0);
    step();
    check("wr.dh.drv",   32'(bus_if.bus_data_drv_b), 32'hDEAD);
    check("wr.dh.oe",    32'(bus_if.dbus_o_en_b),    32'd1);
    check("wr.dh.rspv",  32'(bus_if.core_rsp_valid), 32'd0);
    step();
    check("wr.rsp.valid", 32'(bus_if.core_rsp_valid), 32'd1);
    check("wr.rsp.err",   32'(bus_if.core_rsp_err),   32'd0);
    check("wr.rsp.rdata", bus_if.core_rsp_rdata,      32'd0);
    check("wr.rsp.oe",    32'(bus_if.dbus_o_en_b),    32'd0);
    check("wr.rsp.cs_n",  32'(bus_if.bus_cs_n),       32'd1);
    rsp_handshake("wr.done");

    // Full read with both turnarounds: rsp_valid seven cycles after handshake.
    bus_if.bus_data_recv_b = 16'h5678;
    send_req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    check("rd.ah.drv",  32'(bus_if.bus_data_drv_b), 32'h0000);
    step();
    check("rd.al.drv",  32'(bus_if.bus_data_drv_b), 32'h0100);
    step();
    check("rd.tr.oe",   32'(bus_if.dbus_o_en_b), 32'd0);
    check("rd.tr.ie",   32'(bus_if.dbus_i_en_b), 32'd0);
    check("rd.tr.ale",  32'(bus_if.bus_ale),     32'd0);
    check("rd.tr.cs_n", 32'(bus_if.bus_cs_n),    32'd0);
    step();
    check("rd.dl.ie",   32'(bus_if.dbus_i_en_b), 32'd1);
    check("rd.dl.oe",   32'(bus_if.dbus_o_en_b), 32'd0);
    check("rd.dl.we_n", 32'(bus_if.bus_we_n),    32'd1);
    check("rd.dl.be_n", 32'(bus_if.bus_be_n),    32'd0);
    step();
    bus_if.bus_data_recv_b = 16'h1234;
    check("rd.dh.ie",   32'(bus_if.dbus_i_en_b), 32'd1);
    step();
    check("rd.tb.ie",   32'(bus_if.dbus_i_en_b),    32'd0);
    check("rd.tb.oe",   32'(bus_if.dbus_o_en_b),    32'd0);
    check("rd.tb.cs_n", 32'(bus_if.bus_cs_n),       32'd1);
    check("rd.tb.rspv", 32'(bus_if.core_rsp_valid), 32'd0);
    step();
    check("rd.rsp.valid", 32'(bus_if.core_rsp_valid), 32'd1);
    check("rd.rsp.rdata", bus_if.core_rsp_rdata,      32'h1234_5678);
    check("rd.rsp.err",   32'(bus_if.core_rsp_err),   32'd0);
    rsp_handshake("rd.done");

    // Upper-half read with three wait states; DATA_LO is skipped.
    bus_if.bus_rdy         = 1'b0;
    bus_if.bus_data_recv_b = 16'hABCD;
    send_req(1'b0, 32'h0000_0200, 32'h0, 4'b1100);
    step();
    step();
    step();
    check("rh.dh.ie",   32'(bus_if.dbus_i_en_b), 32'd1);
    check("rh.dh.be_n", 32'(bus_if.bus_be_n),    32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rh.wait.ie",   32'(bus_if.dbus_i_en_b),    32'd1);
      check("rh.wait.rspv", 32'(bus_if.core_rsp_valid), 32'd0);
    end
    bus_if.bus_rdy = 1'b1;
    step();
    check("rh.tb.ie", 32'(bus_if.dbus_i_en_b), 32'd0);
    step();
    check("rh.rsp.valid", 32'(bus_if.core_rsp_valid), 32'd1);
    check("rh.rsp.rdata", bus_if.core_rsp_rdata,      32'hABCD_0000);
    rsp_handshake("rh.done");

    // Write timeout: four wait cycles, abort on the fifth, DATA_HI skipped.
    bus_if.bus_rdy = 1'b0;
    send_req(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hF);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("to.dl.drv",  32'(bus_if.bus_data_drv_b), 32'hAAAA);
      check("to.dl.we_n", 32'(bus_if.bus_we_n),       32'd0);
      check("to.dl.rspv", 32'(bus_if.core_rsp_valid), 32'd0);
    end
    step();
    check("to.rsp.valid", 32'(bus_if.core_rsp_valid), 32'd1);
    check("to.rsp.err",   32'(bus_if.core_rsp_err),   32'd1);
    check("to.rsp.oe",    32'(bus_if.dbus_o_en_b),    32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to.hold.valid", 32'(bus_if.core_rsp_valid), 32'd1);
      check("to.hold.err",   32'(bus_if.core_rsp_err),   32'd1);
    end
    rsp_handshake("to.done");

    // Reset during DATA_LO of a read, then a fresh low-half write.
    send_req(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    step();
    step();
    step();
    check("rst.dl.ie", 32'(bus_if.dbus_i_en_b), 32'd1);
    rst_n = 1'b0;
    step();
    check_idle("rst.mid");
    rst_n          = 1'b1;
    bus_if.bus_rdy = 1'b1;
    send_req(1'b1, 32'h0000_00AA, 32'h1111_2222, 4'b0011);
    check("rst.ah.drv", 32'(bus_if.bus_data_drv_b), 32'h0000);
    step();
    check("rst.al.drv", 32'(bus_if.bus_data_drv_b), 32'h00AA);
    step();
    check("rst.dl.drv",  32'(bus_if.bus_data_drv_b), 32'h2222);
    check("rst.dl.be_n", 32'(bus_if.bus_be_n),       32'd0);
    step();
    check("rst.rsp.valid", 32'(bus_if.core_rsp_valid), 32'd1);
    check("rst.rsp.err",   32'(bus_if.core_rsp_err),   32'd0);
    rsp_handshake("rst.done");

    // Zero byte enables: address phases only, then an empty response.
    bus_if.bus_data_recv_b = 16'hFFFF;
    send_req(1'b0, 32'hCAFE_F00D, 32'h0, 4'b0000);
    check("be0.ah.drv", 32'(bus_if.bus_data_drv_b), 32'hCAFE);
    step();
    check("be0.al.drv", 32'(bus_if.bus_data_drv_b), 32'hF00D);
    step();
    check("be0.rsp.valid", 32'(bus_if.core_rsp_valid), 32'd1);
    check("be0.rsp.rdata", bus_if.core_rsp_rdata,      32'd0);
    check("be0.rsp.err",   32'(bus_if.core_rsp_err),   32'd0);
    check("be0.rsp.ie",    32'(bus_if.dbus_i_en_b),    32'd0);
    rsp_handshake("be0.done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ext_bus_ctrl.md
Name: ext_bus_ctrl

Overview:
- Bus-master sequencer directly upstream of the west pad ring; drives bus_data_drv_b, dbus_o_en_b and dbus_i_en_b, and consumes bus_data_recv_b.
- Converts one 32-bit core data-bus request (valid/ready) into a multiplexed 16-bit external transaction: address hi/lo phases, then one or two data halfwords with bus_rdy wait states.
- Inserts the bus turnaround cycles and a per-halfword timeout.

Parameters:
TIMEOUT, 255, max cycles waiting for bus_rdy per data halfword before aborting with error
CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
core_req_valid  in  1  request valid
core_req_ready  out  1  request accepted when valid&ready
core_req_we  in  1  1=write, 0=read
core_req_addr  in  32  byte address
core_req_wdata  in  32  write data
core_req_be  in  4  byte enables
core_rsp_valid  out  1  response valid, held until accepted
core_rsp_ready  in  1  response accept
core_rsp_rdata  out  32  read data (0 for writes)
core_rsp_err  out  1  timeout error
bus_data_drv_b  out  16  to pad DATA_OUT
dbus_o_en_b  out  1  pad output enable, active high
dbus_i_en_b  out  1  pad input enable, active high
bus_data_recv_b  in  16  from pad DATA_IN
bus_ale  out  1  address latch enable
bus_cs_n  out  1  chip select, active low
bus_we_n  out  1  write strobe, active low
bus_be_n  out  2  halfword byte enables, active low
bus_rdy  in  1  device ready (already synchronised to clk)

Behaviour:
- All outputs are registered. Reset values, applied on any clk edge with rst_n=0 including mid-transaction, abort without a response:
  - core_req_ready=1, core_rsp_valid=0, core_rsp_rdata=0, core_rsp_err=0
  - bus_data_drv_b=0, dbus_o_en_b=0, dbus_i_en_b=0, bus_ale=0, bus_cs_n=1, bus_we_n=1, bus_be_n=2'b11
  - state=IDLE
- States: IDLE, ADDR_HI, ADDR_LO, TURN_R, DATA_LO, DATA_HI, TURN_B, RESP.
- IDLE:
  - core_req_ready=1.
  - On valid&ready, latch we/addr/wdata/be; ready drops the next cycle; go to ADDR_HI.
- ADDR_HI (1 cycle): cs_n=0, ale=1, oe=1, ie=0, drv=addr[31:16].
- ADDR_LO (1 cycle): ale=1, drv=addr[15:0].
  - be==0: go to RESP (err=0, rdata=0).
  - Write: go to DATA_LO if be[1:0]!=0, else DATA_HI.
  - Read: go to TURN_R.
- TURN_R (1 cycle): oe=0, ie=0, ale=0. Go to DATA_LO if be[1:0]!=0, else DATA_HI.
- DATA_LO / DATA_HI:
  - ale=0, bus_be_n=~be[1:0] or ~be[3:2].
  - Write: oe=1, we_n=0, drv=wdata[15:0] or wdata[31:16].
  - Read: ie=1, oe=0, we_n=1.
  - Stay while bus_rdy=0, incrementing wait counter (cleared on entry).
  - Halfword completes in the cycle bus_rdy=1 is sampled. Reads capture bus_data_recv_b into rdata[15:0] or rdata[31:16]; unselected bytes read 0.
  - After DATA_LO: go to DATA_HI if be[3:2]!=0, else finish.
  - Finish: read goes to TURN_B; write goes to RESP.
  - If the counter reaches TIMEOUT with bus_rdy still 0: set err=1, skip remaining halfwords, finish as above.
  - bus_rdy=1 in the same cycle the counter hits TIMEOUT counts as success.
- TURN_B (1 cycle): ie=0, oe=0, cs_n=1. Go to RESP.
  - Guarantees at least one cycle with both enables low between read sampling and any later drive.
- RESP:
  - cs_n=1, oe=0, ie=0, we_n=1, be_n=11; core_rsp_valid=1 with rdata/err stable.
  - On rsp_ready: go to IDLE; rsp_valid clears and rdata/err clear to 0.
  - A new request cannot be accepted before the response handshake.
- Invariant: dbus_o_en_b and dbus_i_en_b never both 1.
- Latency, request handshake to rsp_valid, zero wait states:
  - Full write: 5 cycles.
  - Full read: 7 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Write, addr=0x8000_1234, wdata=0xDEAD_BEEF, be=F, bus_rdy=1 -> drv sequence 0x8000, 0x1234, 0xBEEF, 0xDEAD; ale high on the first two; oe=1 throughout; rsp_valid after 5 cycles, err=0.
- Read, be=F, bus_rdy=1, recv 0x5678 then 0x1234 -> TURN_R and TURN_B cycles with oe=ie=0; rdata=0x1234_5678; never oe&ie.
- Read, be=4'b1100, bus_rdy low for 3 cycles in DATA_HI -> DATA_LO skipped; bus_be_n=00; rdata=0xABCD_0000 for recv 0xABCD.
- Write, bus_rdy held 0, TIMEOUT=4 -> abort after 4 wait cycles; err=1; DATA_HI skipped; rsp_valid held until rsp_ready is asserted 3 cycles later.
- rst_n=0 during DATA_LO of a read -> next cycle all outputs at reset values; no rsp_valid; a new request is accepted normally.
- Request with be=0 -> ADDR_HI and ADDR_LO only, then RESP with rdata=0, err=0.
